// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: program RAM geometry and the loader state encoding.
package sap1_pkg;

    localparam int SAP1_RAM_DEPTH = 16;
    localparam int SAP1_ADDR_W    = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        VERIFY,
        DONE,
        ERROR
    } loader_state_t;

endpackage

// File: rtl/sum8_acc.sv
// 8-bit modular accumulator with synchronous clear (clear wins over accumulate).
module sum8_acc (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] d,
    output logic [7:0] q
);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            q <= 8'h00;
        end else if (clr) begin
            q <= 8'h00;
        end else if (en) begin
            q <= q + d;
        end
    end

endmodule

// File: rtl/ram_loader.sv
// Streams bytes into the SAP-1 program RAM, then reads them back and checks the sum.
module ram_loader
    import sap1_pkg::*;
#(
    parameter int DEPTH     = SAP1_RAM_DEPTH,
    parameter int ADDR_W    = SAP1_ADDR_W,
    parameter bit VERIFY_EN = 1'b1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              ram_prog,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_din,
    output logic              ram_n_ce,
    input  logic [7:0]        ram_dout,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [7:0]        checksum
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    loader_state_t     state;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        wsum;
    logic [7:0]        rsum;
    logic [7:0]        rsum_final;
    logic              idle_like;
    logic              accept_start;
    logic              load_hs;
    logic              last_hs;

    assign idle_like    = (state == IDLE) || (state == DONE) || (state == ERROR);
    assign accept_start = idle_like && start;
    assign load_hs      = (state == LOAD) && s_valid;
    assign last_hs      = load_hs && (addr == LAST_ADDR);
    assign rsum_final   = rsum + ram_dout;

    // Write strobe and data are the only paths straight from the source to the RAM.
    assign ram_prog = s_ready & s_valid;
    assign ram_din  = s_ready ? s_data : 8'h00;
    assign ram_addr = addr;
    assign checksum = wsum;

    sum8_acc u_wsum (
        .clk   (clk),
        .n_rst (n_rst),
        .clr   (accept_start),
        .en    (load_hs),
        .d     (s_data),
        .q     (wsum)
    );

    sum8_acc u_rsum (
        .clk   (clk),
        .n_rst (n_rst),
        .clr   (accept_start || last_hs),
        .en    (state == VERIFY),
        .d     (ram_dout),
        .q     (rsum)
    );

    // addr wraps to 0 on its own at the end of each phase because DEPTH == 2**ADDR_W.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            addr     <= '0;
            s_ready  <= 1'b0;
            ram_n_ce <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state    <= LOAD;
                        addr     <= '0;
                        s_ready  <= 1'b1;
                        ram_n_ce <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        error    <= 1'b0;
                    end
                end
                LOAD: begin
                    if (s_valid) begin
                        addr <= addr + 1'b1;
                        if (addr == LAST_ADDR) begin
                            s_ready <= 1'b0;
                            if (VERIFY_EN) begin
                                state    <= VERIFY;
                                ram_n_ce <= 1'b0;
                            end else begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end
                end
                VERIFY: begin
                    addr <= addr + 1'b1;
                    if (addr == LAST_ADDR) begin
                        ram_n_ce <= 1'b1;
                        busy     <= 1'b0;
                        if (rsum_final == wsum) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ERROR;
                            error <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    addr     <= '0;
                    s_ready  <= 1'b0;
                    ram_n_ce <= 1'b1;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    error    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader with a behavioural 16x8 RAM and a write scoreboard.
module tb_ram_loader;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       start = 1'b0;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_ready;
    logic       ram_prog;
    logic [3:0] ram_addr;
    logic [7:0] ram_din;
    logic       ram_n_ce;
    logic [7:0] ram_dout;
    logic       busy;
    logic       done;
    logic       error;
    logic [7:0] checksum;

    logic [7:0]  mem [16];
    logic        corrupt = 1'b0;
    int          wr_count [16];
    int          ncel = 0;
    logic [11:0] sb [$];
    logic [3:0]  exp_addr = 4'd0;
    logic [7:0]  exp_sum = 8'h00;
    int          checks = 0;
    int          passes = 0;

    always #5 clk = ~clk;

    ram_loader #(.DEPTH(16), .ADDR_W(4), .VERIFY_EN(1'b1)) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .start    (start),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_ready  (s_ready),
        .ram_prog (ram_prog),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_n_ce (ram_n_ce),
        .ram_dout (ram_dout),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .checksum (checksum)
    );

    always @(posedge clk) if (ram_prog) mem[ram_addr] <= ram_din;
    assign ram_dout = ram_n_ce ? 8'h00 : ((corrupt && ram_addr == 4'd5) ? 8'hAA : mem[ram_addr]);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        logic [11:0] e;
        if (!ram_n_ce) ncel++;
        if (ram_prog === 1'b1) begin
            wr_count[ram_addr]++;
            chk("prog_only_with_valid", s_valid, 1'b1);
            if (sb.size() == 0) begin
                chk("unexpected_write", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("write_addr", ram_addr, e[11:8]);
                chk("write_data", ram_din, e[7:0]);
            end
        end
    end

    task automatic clear_tracking();
        for (int i = 0; i < 16; i++) wr_count[i] = 0;
        ncel = 0;
        exp_addr = 4'd0;
        exp_sum = 8'h00;
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that takes LOAD.
    task automatic do_start();
        clear_tracking();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_busy", busy, 1'b1);
        chk("start_ready", s_ready, 1'b1);
        chk("start_addr", ram_addr, 4'd0);
        chk("start_wsum_clear", checksum, 8'h00);
    endtask

    task automatic send_bytes(input logic [7:0] base, input logic [7:0] step,
                              input int gap, input int start_at, input int n);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            d = base + step * 8'(i);
            s_valid = 1'b1;
            s_data  = d;
            start   = (i == start_at);
            sb.push_back({exp_addr, d});
            exp_addr = exp_addr + 4'd1;
            exp_sum  = exp_sum + d;
            @(posedge clk); #1;
            start = 1'b0;
            for (int g = 0; g < gap; g++) begin
                s_valid = 1'b0;
                s_data  = 8'h5A;
                @(posedge clk); #1;
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int max);
        int n = 0;
        while (!(done || error) && n < max) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, (n < max), 1'b1);
    endtask

    task automatic check_writes(input string tag);
        int bad = 0;
        for (int i = 0; i < 16; i++) if (wr_count[i] != 1) bad++;
        chk(tag, bad, 0);
        chk({tag, "_sb_empty"}, sb.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        clear_tracking();

        // Reset values
        #12;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_error", error, 1'b0);
        chk("rst_ready", s_ready, 1'b0);
        chk("rst_prog", ram_prog, 1'b0);
        chk("rst_nce", ram_n_ce, 1'b1);
        chk("rst_addr", ram_addr, 4'd0);
        chk("rst_checksum", checksum, 8'h00);
        @(negedge clk); n_rst = 1'b1;
        @(posedge clk); #1;

        // IDLE ignores the source
        s_valid = 1'b1;
        @(posedge clk); #1;
        chk("idle_ready", s_ready, 1'b0);
        chk("idle_prog", ram_prog, 1'b0);
        s_valid = 1'b0;

        // Fault-free load with exact latency
        do_start();
        send_bytes(8'h00, 8'h01, 0, -1, 16);
        chk("ver_busy", busy, 1'b1);
        chk("ver_nce", ram_n_ce, 1'b0);
        chk("ver_ready", s_ready, 1'b0);
        repeat (15) begin @(posedge clk); #1; end
        chk("c32_done", done, 1'b0);
        chk("c32_busy", busy, 1'b1);
        @(posedge clk); #1;
        chk("c33_done", done, 1'b1);
        chk("c33_busy", busy, 1'b0);
        chk("c33_error", error, 1'b0);
        chk("c33_nce", ram_n_ce, 1'b1);
        chk("c33_addr", ram_addr, 4'd0);
        chk("ff_checksum", checksum, 8'h78);
        chk("ff_model_sum", checksum, exp_sum);
        chk("ff_verify_cycles", ncel, 16);
        check_writes("ff_writes");

        // Restart from DONE with 0xFF bytes
        do_start();
        chk("restart_done_clr", done, 1'b0);
        send_bytes(8'hFF, 8'h00, 0, -1, 16);
        wait_end("wrap_timeout", 40);
        chk("wrap_done", done, 1'b1);
        chk("wrap_checksum", checksum, 8'hF0);
        check_writes("wrap_writes");

        // Backpressure 1,0,0 with a start pulse mid-load that must be ignored
        do_start();
        send_bytes(8'h00, 8'h01, 2, 8, 16);
        wait_end("bp_timeout", 60);
        chk("bp_done", done, 1'b1);
        chk("bp_error", error, 1'b0);
        chk("bp_checksum", checksum, 8'h78);
        chk("bp_verify_cycles", ncel, 16);
        check_writes("bp_writes");

        // Corrupted readback
        corrupt = 1'b1;
        do_start();
        send_bytes(8'h00, 8'h01, 0, -1, 16);
        wait_end("cor_timeout", 40);
        chk("cor_error", error, 1'b1);
        chk("cor_done", done, 1'b0);
        chk("cor_checksum", checksum, 8'h78);
        chk("cor_nce", ram_n_ce, 1'b1);
        corrupt = 1'b0;

        // Reset mid-load after 7 bytes, then reload from address 0
        do_start();
        send_bytes(8'h30, 8'h01, 0, -1, 7);
        s_valid = 1'b1;
        s_data  = 8'h37;
        #2 n_rst = 1'b0;
        #1;
        chk("mid_rst_prog", ram_prog, 1'b0);
        chk("mid_rst_nce", ram_n_ce, 1'b1);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_ready", s_ready, 1'b0);
        chk("mid_rst_addr", ram_addr, 4'd0);
        chk("mid_rst_checksum", checksum, 8'h00);
        chk("mid_rst_writes", wr_count[6] + wr_count[7], 1);
        s_valid = 1'b0;
        @(negedge clk); n_rst = 1'b1;
        @(posedge clk); #1;
        do_start();
        send_bytes(8'h00, 8'h03, 0, -1, 16);
        wait_end("reload_timeout", 40);
        chk("reload_done", done, 1'b1);
        chk("reload_checksum", checksum, 8'h68);
        check_writes("reload_writes");
        chk("reload_mem5", mem[5], 8'h0F);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
